// File: rtl/conv3x3_stream.sv
// Streaming 3x3 raster filter (bypass / Gaussian 1-2-1 / sharpen) with two line buffers and a FILL/RUN/FLUSH frame FSM.
// Build option: define BORDER_REPLICATE_EN for edge-replicate borders; otherwise out-of-frame taps read as zero.
module conv3x3_stream #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [DATA_W-1:0]         pixel_in,
   input  logic                      vsync,
   input  logic                      active_area,
   input  logic [1:0]                mode,
   output logic [DATA_W-1:0]         pixel_out,
   output logic                      pixel_valid,
   output logic [$clog2(IMG_W)-1:0]  out_col,
   output logic [$clog2(IMG_H)-1:0]  out_row,
   output logic                      overrun
);

   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = $clog2(IMG_H);
   localparam int IRW = $clog2(IMG_H + 2);
   localparam int SW  = DATA_W + 4;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

   state_t              r_state, w_next;
   logic                r_vs_d, r_fl_done;
   logic [1:0]          r_mode;
   logic [CW-1:0]       r_in_col, r_c_col, r_wcol, r_scol, w_col_in;
   logic [IRW-1:0]      r_in_row;
   logic [RW-1:0]       r_c_row, r_wrow, r_srow;
   logic                r_wv, r_sv;
   logic [SW-1:0]       r_sum, w_sum, w_gsum, w_sharp;
   logic [DATA_W-1:0]   r_lb0 [IMG_W];
   logic [DATA_W-1:0]   r_lb1 [IMG_W];
   logic [DATA_W-1:0]   r_win [3][3];
   logic [DATA_W-1:0]   w_t   [3][3];
   logic [DATA_W-1:0]   w_pix, w_out;
   logic                w_vs_rise, w_ext, w_stb, w_emit;
   logic                w_top_out, w_bot_out, w_left_out, w_right_out;

   function automatic logic [SW-1:0] ext(input logic [DATA_W-1:0] x);
      return {4'b0000, x};
   endfunction

   assign w_vs_rise = vsync & ~r_vs_d;
   assign w_ext     = enable & active_area;
   assign w_col_in  = w_vs_rise ? CW'(0) : r_in_col;
   assign w_emit    = w_stb & ~w_vs_rise & ((r_state == S_RUN) | (r_state == S_FLUSH));

   // Strobe source: external pixels while filling/running, self-generated zero pixels while flushing.
   always_comb begin
      w_stb = 1'b0;
      w_pix = pixel_in;
      if (w_vs_rise) begin
         w_stb = w_ext;
      end else if ((r_state == S_FILL) || (r_state == S_RUN)) begin
         w_stb = w_ext;
      end else if (r_state == S_FLUSH) begin
         w_stb = ~r_fl_done;
         w_pix = {DATA_W{1'b0}};
      end else begin
         w_stb = 1'b0;
      end
   end

   // Frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state; FLUSH is held until the last result has left the pipeline so no valid appears in IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = S_IDLE;
         S_FILL:  begin
            if (w_stb && (r_in_row == IRW'(1)) && (r_in_col == CW'(0))) w_next = S_RUN;
            else                                                        w_next = S_FILL;
         end
         S_RUN:   begin
            if (w_stb && (r_in_row == IRW'(IMG_H-1)) && (r_in_col == CW'(IMG_W-1))) w_next = S_FLUSH;
            else                                                                     w_next = S_RUN;
         end
         S_FLUSH: begin
            if (r_fl_done && !r_wv && !r_sv) w_next = S_IDLE;
            else                             w_next = S_FLUSH;
         end
         default: w_next = S_IDLE;
      endcase
      if (w_vs_rise) w_next = S_FILL;
   end

   // Input/centre position counters, frame mode and the sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d    <= 1'b0;
         r_mode    <= 2'b00;
         r_in_col  <= CW'(0);
         r_in_row  <= IRW'(0);
         r_c_col   <= CW'(0);
         r_c_row   <= RW'(0);
         r_fl_done <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         r_vs_d <= vsync;
         if (w_vs_rise) begin
            r_mode    <= mode;
            r_in_col  <= w_ext ? CW'(1) : CW'(0);
            r_in_row  <= IRW'(0);
            r_c_col   <= CW'(0);
            r_c_row   <= RW'(0);
            r_fl_done <= 1'b0;
            overrun   <= 1'b0;
         end else begin
            if (w_stb) begin
               if (r_in_col == CW'(IMG_W-1)) begin
                  r_in_col <= CW'(0);
                  r_in_row <= r_in_row + IRW'(1);
               end else begin
                  r_in_col <= r_in_col + CW'(1);
               end
            end
            if (w_emit) begin
               if (r_c_col == CW'(IMG_W-1)) begin
                  r_c_col <= CW'(0);
                  r_c_row <= r_c_row + RW'(1);
                  if (r_c_row == RW'(IMG_H-1)) r_fl_done <= 1'b1;
               end else begin
                  r_c_col <= r_c_col + CW'(1);
               end
            end
            if ((r_state == S_FLUSH) && w_ext) overrun <= 1'b1;
         end
      end
   end

   // Line buffers and window; stale contents are masked by the border logic, so no reset.
   always_ff @(posedge clk) begin
      if (w_stb) begin
         r_lb0[w_col_in] <= w_pix;
         r_lb1[w_col_in] <= r_lb0[w_col_in];
         for (int r = 0; r < 3; r++) begin
            r_win[0][r] <= r_win[1][r];
            r_win[1][r] <= r_win[2][r];
         end
         r_win[2][0] <= r_lb1[w_col_in];
         r_win[2][1] <= r_lb0[w_col_in];
         r_win[2][2] <= w_pix;
      end
   end

   assign w_top_out   = (r_wrow == RW'(0));
   assign w_bot_out   = (r_wrow == RW'(IMG_H-1));
   assign w_left_out  = (r_wcol == CW'(0));
   assign w_right_out = (r_wcol == CW'(IMG_W-1));

`ifdef BORDER_REPLICATE_EN
   logic [DATA_W-1:0] w_v [3][3];

   // Edge replicate: fix rows first, then columns, so corners take the nearest in-frame pixel.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         w_v[c][0] = w_top_out ? r_win[c][1] : r_win[c][0];
         w_v[c][1] = r_win[c][1];
         w_v[c][2] = w_bot_out ? r_win[c][1] : r_win[c][2];
      end
      for (int r = 0; r < 3; r++) begin
         w_t[0][r] = w_left_out  ? w_v[1][r] : w_v[0][r];
         w_t[1][r] = w_v[1][r];
         w_t[2][r] = w_right_out ? w_v[1][r] : w_v[2][r];
      end
   end
`else
   // Zero border: any tap in an out-of-frame row or column reads as 0 (also stops line wrap).
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         for (int r = 0; r < 3; r++) begin
            w_t[c][r] = (((r == 0) && w_top_out)  || ((r == 2) && w_bot_out) ||
                         ((c == 0) && w_left_out) || ((c == 2) && w_right_out))
                        ? {DATA_W{1'b0}} : r_win[c][r];
         end
      end
   end
`endif

   // Kernel arithmetic; w_t is indexed [column][row].
   always_comb begin
      w_gsum  = ext(w_t[0][0]) + ext(w_t[2][0]) + ext(w_t[0][2]) + ext(w_t[2][2])
              + ((ext(w_t[1][0]) + ext(w_t[0][1]) + ext(w_t[2][1]) + ext(w_t[1][2])) << 1'b1)
              + (ext(w_t[1][1]) << 2'd2);
      w_sharp = (ext(w_t[1][1]) << 2'd2) + ext(w_t[1][1])
              - ext(w_t[1][0]) - ext(w_t[1][2]) - ext(w_t[0][1]) - ext(w_t[2][1]);
      case (r_mode)
         2'b00:   w_sum = ext(w_t[1][1]);
         2'b10:   w_sum = w_sharp;
         default: w_sum = w_gsum;
      endcase
   end

   // Sum-to-pixel: truncate Gaussian, clamp signed sharpen result.
   always_comb begin
      w_out = r_sum[SW-1:4];
      case (r_mode)
         2'b00: w_out = r_sum[DATA_W-1:0];
         2'b10: begin
            if (r_sum[SW-1])                 w_out = {DATA_W{1'b0}};
            else if (|r_sum[SW-2:DATA_W])    w_out = {DATA_W{1'b1}};
            else                             w_out = r_sum[DATA_W-1:0];
         end
         default: w_out = r_sum[SW-1:4];
      endcase
   end

   // Window-qualifier, sum and output pipeline; a vsync rise kills anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wv        <= 1'b0;
         r_wcol      <= CW'(0);
         r_wrow      <= RW'(0);
         r_sv        <= 1'b0;
         r_sum       <= SW'(0);
         r_scol      <= CW'(0);
         r_srow      <= RW'(0);
         pixel_valid <= 1'b0;
         pixel_out   <= {DATA_W{1'b0}};
         out_col     <= CW'(0);
         out_row     <= RW'(0);
      end else begin
         r_wv <= w_emit;
         if (w_emit) begin
            r_wcol <= r_c_col;
            r_wrow <= r_c_row;
         end
         r_sv <= r_wv & ~w_vs_rise;
         if (r_wv) begin
            r_sum  <= w_sum;
            r_scol <= r_wcol;
            r_srow <= r_wrow;
         end
         pixel_valid <= r_sv & ~w_vs_rise;
         if (r_sv) begin
            pixel_out <= w_out;
            out_col   <= r_scol;
            out_row   <= r_srow;
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream at 8x6: frame table + spot table, scoreboard from a 2D reference model,
// plus hand-written abort, overrun and reset-in-FLUSH sequences. Works with or without BORDER_REPLICATE_EN.
module tb_conv3x3_stream;
   localparam int W = 8;
   localparam int H = 6;
   localparam int DW = 8;
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst_n, enable, vsync, active_area, pixel_valid, overrun;
   logic [DW-1:0] pixel_in, pixel_out;
   logic [1:0]    mode;
   logic [2:0]    out_col, out_row;

   conv3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_in(pixel_in), .vsync(vsync),
      .active_area(active_area), .mode(mode), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
      .out_col(out_col), .out_row(out_row), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct { int row; int col; int val; } exp_t;
   typedef struct { int pat; logic [1:0] m; bit gaps; bit vs_pix; } frame_t;
   typedef struct { int fr; int row; int col; int exp_zero; int exp_rep; } spot_t;

   exp_t   sb[$];
   exp_t   mon_e;
   frame_t ft[6];
   spot_t  st[18];
   int     img [H][W];
   int     cap [NPIX];
   int     vcyc[NPIX];
   int     cyc = 0;
   int     n_checks = 0, n_pass = 0, n_out = 0, t9 = 0, n0 = 0, mon_idx, sexp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int tap(input int r, input int c);
`ifdef BORDER_REPLICATE_EN
      if (r < 0) r = 0;
      if (r > H - 1) r = H - 1;
      if (c < 0) c = 0;
      if (c > W - 1) c = W - 1;
      return img[r][c];
`else
      if (r < 0 || r >= H || c < 0 || c >= W) return 0;
      return img[r][c];
`endif
   endfunction

   function automatic int model(input int r, input int c, input logic [1:0] m);
      int s;
      if (m == 2'b00) return tap(r, c);
      if (m == 2'b10) begin
         s = 5 * tap(r, c) - tap(r-1, c) - tap(r+1, c) - tap(r, c-1) - tap(r, c+1);
         if (s < 0) s = 0;
         if (s > 255) s = 255;
         return s;
      end
      s = tap(r-1, c-1) + tap(r-1, c+1) + tap(r+1, c-1) + tap(r+1, c+1)
        + 2 * (tap(r-1, c) + tap(r+1, c) + tap(r, c-1) + tap(r, c+1)) + 4 * tap(r, c);
      return s / 16;
   endfunction

   task automatic fill_img(input int pat);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (pat)
               0: img[r][c] = 100;
               1: img[r][c] = r * W + c;
               2: img[r][c] = (r == 2 && c == 3) ? 255 : 0;
               default: img[r][c] = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) * 255)
                                                                 : int'($urandom_range(0, 255));
            endcase
      for (int i = 0; i < NPIX; i++) begin
         cap[i] = -1;
         vcyc[i] = -1;
      end
   endtask

   task automatic push_expected(input logic [1:0] m, input int first, input int last);
      exp_t e;
      for (int i = first; i <= last; i++) begin
         e.row = i / W;
         e.col = i % W;
         e.val = model(e.row, e.col, m);
         sb.push_back(e);
      end
   endtask

   // Drives one frame (or its first npix pixels); mode is corrupted after it is sampled.
   task automatic drive_pixels(input logic [1:0] m, input bit vs_pix, input bit gaps, input int npix);
      mode = m;
      active_area = 1'b1;
      if (!vs_pix) begin
         vsync = 1'b1;
         enable = 1'b0;
         step();
         vsync = 1'b0;
         mode = ~m;
      end
      for (int k = 0; k < npix; k++) begin
         if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
            enable = 1'($urandom_range(0, 1));
            active_area = 1'b0;
            pixel_in = DW'($urandom_range(0, 255));
            step();
            active_area = 1'b1;
         end
         enable = 1'b1;
         pixel_in = DW'(img[k / W][k % W]);
         vsync = vs_pix && (k == 0);
         if (k == 9) t9 = cyc;
         step();
         if (k == 0) begin
            vsync = 1'b0;
            mode = ~m;
         end
      end
      enable = 1'b0;
      vsync = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int i = 0;
      while (sb.size() != 0 && i < 200) begin
         step();
         i++;
      end
      check(name, sb.size(), 0);
      sb.delete();
      repeat (3) step();
   endtask

   // Scoreboard consumer: every valid output must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && pixel_valid === 1'b1) begin
         n_out++;
         mon_idx = int'(out_row) * W + int'(out_col);
         if (mon_idx < NPIX) begin
            cap[mon_idx] = int'(pixel_out);
            vcyc[mon_idx] = cyc;
         end
         if (sb.size() == 0) begin
            check("unexpected_output", mon_idx, -1);
         end else begin
            mon_e = sb.pop_front();
            check("out_pos", mon_idx, mon_e.row * W + mon_e.col);
            check("out_data", int'(pixel_out), mon_e.val);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; active_area = 1'b0; pixel_in = '0; mode = 2'b00;
      ft[0] = '{0, 2'b01, 1'b0, 1'b0};
      ft[1] = '{1, 2'b00, 1'b0, 1'b0};
      ft[2] = '{2, 2'b10, 1'b1, 1'b1};
      ft[3] = '{3, 2'b11, 1'b1, 1'b0};
      ft[4] = '{3, 2'b10, 1'b0, 1'b1};
      ft[5] = '{3, 2'b01, 1'b1, 1'b0};
      st[0]  = '{0, 0, 0, 56, 100};   st[1]  = '{0, 0, 7, 56, 100};
      st[2]  = '{0, 5, 0, 56, 100};   st[3]  = '{0, 5, 7, 56, 100};
      st[4]  = '{0, 0, 3, 75, 100};   st[5]  = '{0, 2, 0, 75, 100};
      st[6]  = '{0, 5, 4, 75, 100};   st[7]  = '{0, 3, 7, 75, 100};
      st[8]  = '{0, 3, 3, 100, 100};  st[9]  = '{1, 0, 0, 0, 0};
      st[10] = '{1, 2, 5, 21, 21};    st[11] = '{1, 5, 7, 47, 47};
      st[12] = '{2, 2, 3, 255, 255};  st[13] = '{2, 1, 3, 0, 0};
      st[14] = '{2, 3, 3, 0, 0};      st[15] = '{2, 2, 2, 0, 0};
      st[16] = '{2, 2, 4, 0, 0};      st[17] = '{2, 4, 6, 0, 0};

      repeat (3) step();
      check("reset_valid", int'(pixel_valid), 0);
      check("reset_pixel", int'(pixel_out), 0);
      check("reset_col", int'(out_col), 0);
      check("reset_row", int'(out_row), 0);
      check("reset_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      step();

      for (int f = 0; f < 6; f++) begin
         fill_img(ft[f].pat);
         n0 = n_out;
         push_expected(ft[f].m, 0, NPIX - 1);
         drive_pixels(ft[f].m, ft[f].vs_pix, ft[f].gaps, NPIX);
         wait_drain("frame_drain");
         check("frame_count", n_out - n0, NPIX);
         check("first_valid_latency", vcyc[0], t9 + 3);
         check("flush_consecutive", vcyc[NPIX-1] - vcyc[NPIX-9], 8);
         check("overrun_clear", int'(overrun), 0);
         for (int i = 0; i < 18; i++) begin
            if (st[i].fr == f) begin
`ifdef BORDER_REPLICATE_EN
               sexp = st[i].exp_rep;
`else
               sexp = st[i].exp_zero;
`endif
               check("spot_value", cap[st[i].row * W + st[i].col], sexp);
            end
         end
      end

      // Abort after row 3: centres 21/22 in flight are dropped; new frame starts on the same clk as vsync.
      fill_img(3);
      n0 = n_out;
      push_expected(2'b01, 0, 20);
      drive_pixels(2'b01, 1'b0, 1'b0, 32);
      fill_img(3);
      push_expected(2'b10, 0, NPIX - 1);
      drive_pixels(2'b10, 1'b1, 1'b0, NPIX);
      wait_drain("abort_drain");
      check("abort_count", n_out - n0, 21 + NPIX);
      check("abort_new_latency", vcyc[0], t9 + 3);

      // Strobes during FLUSH are dropped and latch overrun until the next vsync rise.
      fill_img(3);
      n0 = n_out;
      push_expected(2'b01, 0, NPIX - 1);
      drive_pixels(2'b01, 1'b0, 1'b0, NPIX);
      enable = 1'b1;
      active_area = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pixel_in = DW'($urandom_range(0, 255));
         step();
      end
      enable = 1'b0;
      wait_drain("overrun_drain");
      check("overrun_count", n_out - n0, NPIX);
      check("overrun_set", int'(overrun), 1);
      repeat (5) step();
      check("overrun_sticky", int'(overrun), 1);
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      check("overrun_vsync_clear", int'(overrun), 0);
      step();

      // Reset in the middle of FLUSH, then strobes without vsync must produce nothing.
      fill_img(3);
      push_expected(2'b00, 0, NPIX - 1);
      drive_pixels(2'b00, 1'b0, 1'b0, NPIX);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("rst_flush_valid", int'(pixel_valid), 0);
      check("rst_flush_pixel", int'(pixel_out), 0);
      check("rst_flush_col", int'(out_col), 0);
      check("rst_flush_row", int'(out_row), 0);
      check("rst_flush_overrun", int'(overrun), 0);
      sb.delete();
      step();
      rst_n = 1'b1;
      n0 = n_out;
      enable = 1'b1;
      active_area = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pixel_in = DW'($urandom_range(0, 255));
         step();
      end
      enable = 1'b0;
      repeat (4) step();
      check("post_reset_silent", n_out - n0, 0);
      fill_img(3);
      n0 = n_out;
      push_expected(2'b01, 0, NPIX - 1);
      drive_pixels(2'b01, 1'b0, 1'b1, NPIX);
      wait_drain("post_reset_drain");
      check("post_reset_count", n_out - n0, NPIX);
      check("post_reset_latency", vcyc[0], t9 + 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 The module SHALL have parameter IMG_W, default 320, pixels per line; line-buffer depth.
REQ-003 The module SHALL have parameter IMG_H, default 240, lines per frame.
REQ-004 Port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port enable  input  1  pixel strobe; pixel_in is valid when enable && active_area.
REQ-007 Port pixel_in  input  DATA_W  raster-order input pixel.
REQ-008 Port vsync  input  1  frame start; the rising edge is significant.
REQ-009 Port active_area  input  1  strobe qualifier; when low, strobes are ignored.
REQ-010 Port mode  input  2  00 bypass, 01 Gaussian 1-2-1/16, 10 sharpen, 11 treated as 01.
REQ-011 Port pixel_out  output  DATA_W  filtered centre pixel.
REQ-012 Port pixel_valid  output  1  one-cycle qualifier for pixel_out.
REQ-013 Port out_col  output  clog2(IMG_W)  column of the emitted centre.
REQ-014 Port out_row  output  clog2(IMG_H)  row of the emitted centre.
REQ-015 Port overrun  output  1  sticky flag: a strobe was dropped during FLUSH.

Function
REQ-016 Two IMG_W-deep line buffers plus a 3x3 window SHALL hold rows r-1, r, r+1 around the centre.
REQ-017 FSM states: IDLE, FILL, RUN, FLUSH.
- IDLE -> FILL on vsync rise.
- FILL -> RUN when input linear index reaches IMG_W+1.
- RUN -> FLUSH after input (IMG_H-1, IMG_W-1).
- FLUSH -> IDLE after IMG_W+1 internal strobes.
REQ-018 Input pixel index k (linear) SHALL produce the centre at index k-(IMG_W+1) when k >= IMG_W+1.
REQ-019 In FLUSH, the block SHALL self-generate IMG_W+1 strobes, one per clk, treating row IMG_H as out-of-frame; each frame emits exactly IMG_W*IMG_H outputs.
REQ-020 pixel_valid, pixel_out, out_col and out_row SHALL appear exactly 2 clk after the strobe that completes the centre's window (window -> sum register -> output register).
REQ-021 Window taps outside the frame (row -1, row IMG_H, column -1, column IMG_W) SHALL be substituted per REQ-031/REQ-032; columns SHALL never wrap into the adjacent line.
REQ-022 Gaussian: the sum SHALL be DATA_W+4 bits unsigned, corners x1, edges x2, centre x4; output = sum[DATA_W+3:4] (truncate).
REQ-023 Sharpen: 5*centre minus the 4 edge neighbours, computed signed at DATA_W+4 bits, then clamped to [0, 2^DATA_W-1].
REQ-024 Bypass SHALL output the window centre with the same 2-clk latency.
REQ-025 mode SHALL be sampled on vsync rise and held for the whole frame, including FLUSH.
REQ-026 A vsync rise in any state SHALL abort the current frame: counters cleared, in-flight pipeline results suppressed, state -> FILL.
REQ-027 A vsync rise and a strobe on the same clk: the strobe SHALL be taken as pixel (0,0) of the new frame.
REQ-028 Strobes during FLUSH SHALL be dropped and SHALL set overrun; overrun clears only on vsync rise or reset.
REQ-029 Strobes in IDLE SHALL be ignored; pixel_valid SHALL be 0 in IDLE.

Reset
REQ-030 rst_n low SHALL immediately force pixel_out=0, pixel_valid=0, out_col=0, out_row=0, overrun=0 and state=IDLE. Line-buffer contents are not cleared; they are masked by the counters.

Configuration
REQ-031 With BORDER_REPLICATE_EN defined, each out-of-frame tap SHALL take the nearest in-frame pixel (edge replicate).
REQ-032 Without BORDER_REPLICATE_EN, out-of-frame taps SHALL be 0, and the replicate mux logic SHALL be absent.

Verification (IMG_W=8, IMG_H=6, DATA_W=8)
REQ-033 Constant 100 frame, mode 01, macro on -> all 48 outputs = 100; macro off -> corners 56, non-corner border 75, interior 100.
REQ-034 Ramp pixel = linear index, mode 00 -> outputs 0..47 in order with matching out_row/out_col; first pixel_valid exactly 2 clk after input index 9; last 9 outputs come from FLUSH on consecutive clks.
REQ-035 Impulse 255 at (2,3), else 0, mode 10 -> (2,3)=255 (clamped), its 4 neighbours=0 (clamped from -255), all others 0.
REQ-036 vsync rise after input row 3 -> no further outputs from the old frame; the next frame's first pixel_valid comes 2 clk after its index 9.
REQ-037 rst_n low mid-FLUSH -> all outputs 0 in the same cycle; after release, pixel_valid stays 0 until a vsync rise and index 9.
REQ-038 Strobe during FLUSH -> pixel dropped, overrun=1 held until the next vsync rise, output count still 48.
